// File: rtl/ga_pkg.sv
// Shared types, constants and helpers for the genetic-pipeline mutation blocks.
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    PICK   = 3'd2,
    SWAP   = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int unsigned SEED_W         = 32;
  localparam logic [31:0] LFSR_MASK      = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_RESET     = 32'h0000_0001;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Bit offset of gene idx inside a flattened genome.
  function automatic int unsigned gene_lsb(input int unsigned idx, input int unsigned gene_w);
    return idx * gene_w;
  endfunction

endpackage

// File: rtl/swap_mutator_if.sv
// Request/response bundle between parent selection, the swap mutator and fitness evaluation.
interface swap_mutator_if
  import ga_pkg::*;
#(
  parameter int unsigned GENE_W    = 5,
  parameter int unsigned NUM_GENES = 30,
  parameter int unsigned MAX_SWAPS = 3
);
  localparam int unsigned CNT_W = clog2(MAX_SWAPS + 1);
  localparam int unsigned G_W   = GENE_W * NUM_GENES;

  logic              start;
  logic [SEED_W-1:0] seed;
  logic [G_W-1:0]    parent;
  logic              count_sel;
  logic [CNT_W-1:0]  count_in;
  logic              busy;
  logic [G_W-1:0]    mutant;
  logic [CNT_W-1:0]  swaps_done;
  logic              done;

  modport master (
    output start, seed, parent, count_sel, count_in,
    input  busy, mutant, swaps_done, done
  );

  modport slave (
    input  start, seed, parent, count_sel, count_in,
    output busy, mutant, swaps_done, done
  );

endinterface

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with seed load and step enable; a zero seed is replaced so it never locks up.
module lfsr32_galois
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 32'h0) ? LFSR_ZERO_SEED : seed_i;
    end else if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_RESET;
    else     lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/swap_mutator.sv
// Swap mutation: applies 0..MAX_SWAPS LFSR-chosen pairwise gene swaps to a latched parent genome.
module swap_mutator
  import ga_pkg::*;
#(
  parameter int unsigned GENE_W    = 5,
  parameter int unsigned NUM_GENES = 30,
  parameter int unsigned MAX_SWAPS = 3
) (
  input  logic           clk,
  input  logic           rst,
  swap_mutator_if.slave  bus
);

  localparam int unsigned IDX_W = clog2(NUM_GENES);
  localparam int unsigned CNT_W = clog2(MAX_SWAPS + 1);
  localparam int unsigned G_W   = GENE_W * NUM_GENES;

  state_e            state_q;
  logic [G_W-1:0]    work_q;
  logic [G_W-1:0]    mutant_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  swaps_q;
  logic [CNT_W-1:0]  swaps_done_q;
  logic [IDX_W-1:0]  a_q;
  logic [IDX_W-1:0]  b_q;
  logic              busy_q;
  logic              done_q;

  logic [SEED_W-1:0] lfsr_val;
  logic              lfsr_load_c;
  logic              lfsr_step_c;
  logic              unused_lfsr_c;

  logic [CNT_W-1:0]  cand_c;
  logic              cand_ok_c;
  logic [CNT_W-1:0]  forced_c;
  logic [IDX_W-1:0]  pick_a_c;
  logic [IDX_W-1:0]  pick_b_c;
  logic              pick_ok_c;
  logic [G_W-1:0]    swapped_c;

  assign lfsr_load_c = (state_q == IDLE) && bus.start;
  assign lfsr_step_c = (state_q == COUNT) || (state_q == PICK);

  lfsr32_galois u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load_c),
    .seed_i  (bus.seed),
    .step_i  (lfsr_step_c),
    .value_o (lfsr_val)
  );

  assign unused_lfsr_c = ^lfsr_val;

  // Swap-count candidates: random draws are rejection-sampled, forced counts are clamped.
  assign cand_c    = lfsr_val[CNT_W-1:0];
  assign cand_ok_c = {1'b0, cand_c} <= (CNT_W+1)'(MAX_SWAPS);
  assign forced_c  = ({1'b0, bus.count_in} > (CNT_W+1)'(MAX_SWAPS)) ? CNT_W'(MAX_SWAPS)
                                                                    : bus.count_in;

  assign pick_a_c  = lfsr_val[IDX_W-1:0];
  assign pick_b_c  = lfsr_val[2*IDX_W-1:IDX_W];
  assign pick_ok_c = (32'(pick_a_c) < NUM_GENES) && (32'(pick_b_c) < NUM_GENES) &&
                     (pick_a_c != pick_b_c);

  always_comb begin
    swapped_c = work_q;
    swapped_c[gene_lsb(32'(a_q), GENE_W) +: GENE_W] = work_q[gene_lsb(32'(b_q), GENE_W) +: GENE_W];
    swapped_c[gene_lsb(32'(b_q), GENE_W) +: GENE_W] = work_q[gene_lsb(32'(a_q), GENE_W) +: GENE_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      work_q       <= '0;
      mutant_q     <= '0;
      remaining_q  <= '0;
      swaps_q      <= '0;
      swaps_done_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q  <= bus.parent;
            swaps_q <= '0;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (bus.count_sel) begin
            remaining_q <= forced_c;
            state_q     <= (forced_c == '0) ? FINISH : PICK;
          end else if (cand_ok_c) begin
            remaining_q <= cand_c;
            state_q     <= (cand_c == '0) ? FINISH : PICK;
          end
        end
        PICK: begin
          if (pick_ok_c) begin
            a_q     <= pick_a_c;
            b_q     <= pick_b_c;
            state_q <= SWAP;
          end
        end
        SWAP: begin
          work_q      <= swapped_c;
          swaps_q     <= swaps_q + CNT_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
          state_q     <= (remaining_q == CNT_W'(1)) ? FINISH : PICK;
        end
        FINISH: begin
          mutant_q     <= work_q;
          swaps_done_q <= swaps_q;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.mutant     = mutant_q;
  assign bus.swaps_done = swaps_done_q;
  assign bus.done       = done_q;

endmodule
